// File: rtl/edge_auto_threshold.sv
// Per-frame edge counter and closed-loop Sobel threshold stepper.
// Define EDGE_AUTO_THRESHOLD_BBOX_EN to add edge bounding-box tracking.
module edge_auto_threshold #(
  parameter logic [10:0] TH_INIT = 11'd100,
  parameter logic [10:0] TH_MIN  = 11'd16,
  parameter logic [10:0] TH_MAX  = 11'd1020,
  parameter logic [10:0] STEP    = 11'd8,
  parameter logic [18:0] CNT_LO  = 19'd9216,
  parameter logic [18:0] CNT_HI  = 19'd30720
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        sobel_dout,
  input  logic        sobel_hs,
  input  logic        sobel_vs,
  input  logic        sobel_de,
  input  logic        update_en,
  output logic [10:0] threshold,
  output logic [18:0] edge_count,
  output logic        stats_valid,
  output logic        bbox_valid,
  output logic [10:0] x_min,
  output logic [10:0] x_max,
  output logic [10:0] y_min,
  output logic [10:0] y_max
);

  typedef enum logic [1:0] {IDLE, ACCUM, LATCH, ADJUST} state_t;

  state_t             state_r;
  logic               vs_d_r;
  logic [18:0]        acc_r;
  logic               vs_rise_s;
  logic               pix_edge_s;
  logic               hs_unused_s;
  logic [11:0]        th_sum_s;
  logic signed [11:0] th_diff_s;
  logic signed [12:0] th_cand_s;
  logic [10:0]        th_next_s;

  assign vs_rise_s   = sobel_vs & ~vs_d_r;
  assign pix_edge_s  = sobel_de & ~sobel_dout;
  assign hs_unused_s = sobel_hs;

  // Next threshold: step toward the band, then clamp into [TH_MIN, TH_MAX].
  always_comb begin
    th_sum_s  = {1'b0, threshold} + {1'b0, STEP};
    th_diff_s = $signed({1'b0, threshold}) - $signed({1'b0, STEP});
    if (update_en && (edge_count > CNT_HI)) begin
      th_cand_s = $signed({1'b0, th_sum_s});
    end else if (update_en && (edge_count < CNT_LO)) begin
      th_cand_s = {th_diff_s[11], th_diff_s};
    end else begin
      th_cand_s = $signed({2'b00, threshold});
    end
    if (th_cand_s > $signed({2'b00, TH_MAX})) begin
      th_next_s = TH_MAX;
    end else if (th_cand_s < $signed({2'b00, TH_MIN})) begin
      th_next_s = TH_MIN;
    end else begin
      th_next_s = th_cand_s[10:0];
    end
  end

  // Frame FSM with edge accumulator, latched count and threshold register.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      vs_d_r      <= 1'b0;
      acc_r       <= 19'd0;
      edge_count  <= 19'd0;
      threshold   <= TH_INIT;
      stats_valid <= 1'b0;
    end else begin
      vs_d_r      <= sobel_vs;
      stats_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (vs_rise_s) begin
            acc_r   <= 19'd0;
            state_r <= ACCUM;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCUM: begin
          if (pix_edge_s && (acc_r != 19'h7FFFF)) begin
            acc_r <= acc_r + 19'd1;
          end else begin
            acc_r <= acc_r;
          end
          state_r <= vs_rise_s ? LATCH : ACCUM;
        end
        LATCH: begin
          edge_count <= acc_r;
          acc_r      <= 19'd0;
          state_r    <= ADJUST;
        end
        ADJUST: begin
          threshold   <= th_next_s;
          stats_valid <= 1'b1;
          state_r     <= ACCUM;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef EDGE_AUTO_THRESHOLD_BBOX_EN
  logic        de_d_r;
  logic [10:0] col_r;
  logic [10:0] row_r;
  logic [10:0] xmin_r;
  logic [10:0] xmax_r;
  logic [10:0] ymin_r;
  logic [10:0] ymax_r;
  logic        de_fall_s;

  assign de_fall_s = de_d_r & ~sobel_de;

  // Pixel position counters; both saturate at 2047.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      de_d_r <= 1'b0;
      col_r  <= 11'd0;
      row_r  <= 11'd0;
    end else begin
      de_d_r <= sobel_de;
      if (vs_rise_s) begin
        col_r <= 11'd0;
        row_r <= 11'd0;
      end else begin
        if (sobel_de) begin
          col_r <= (col_r != 11'd2047) ? col_r + 11'd1 : col_r;
        end else if (de_fall_s) begin
          col_r <= 11'd0;
        end else begin
          col_r <= col_r;
        end
        if (de_fall_s && (row_r != 11'd2047)) begin
          row_r <= row_r + 11'd1;
        end else begin
          row_r <= row_r;
        end
      end
    end
  end

  // Running bounding box and its per-frame publication in LATCH.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      xmin_r     <= 11'd2047;
      xmax_r     <= 11'd0;
      ymin_r     <= 11'd2047;
      ymax_r     <= 11'd0;
      bbox_valid <= 1'b0;
      x_min      <= 11'd0;
      x_max      <= 11'd0;
      y_min      <= 11'd0;
      y_max      <= 11'd0;
    end else begin
      if (((state_r == IDLE) && vs_rise_s) || (state_r == LATCH)) begin
        xmin_r <= 11'd2047;
        xmax_r <= 11'd0;
        ymin_r <= 11'd2047;
        ymax_r <= 11'd0;
      end else if ((state_r == ACCUM) && pix_edge_s) begin
        xmin_r <= (col_r < xmin_r) ? col_r : xmin_r;
        xmax_r <= (col_r > xmax_r) ? col_r : xmax_r;
        ymin_r <= (row_r < ymin_r) ? row_r : ymin_r;
        ymax_r <= (row_r > ymax_r) ? row_r : ymax_r;
      end else begin
        xmin_r <= xmin_r;
        xmax_r <= xmax_r;
        ymin_r <= ymin_r;
        ymax_r <= ymax_r;
      end
      if ((state_r == LATCH) && (acc_r != 19'd0)) begin
        bbox_valid <= 1'b1;
        x_min      <= xmin_r;
        x_max      <= xmax_r;
        y_min      <= ymin_r;
        y_max      <= ymax_r;
      end else if (state_r == LATCH) begin
        bbox_valid <= 1'b0;
        x_min      <= 11'd0;
        x_max      <= 11'd0;
        y_min      <= 11'd0;
        y_max      <= 11'd0;
      end else begin
        bbox_valid <= bbox_valid;
        x_min      <= x_min;
        x_max      <= x_max;
        y_min      <= y_min;
        y_max      <= y_max;
      end
    end
  end
`else
  assign bbox_valid = 1'b0;
  assign x_min      = 11'd0;
  assign x_max      = 11'd0;
  assign y_min      = 11'd0;
  assign y_max      = 11'd0;
`endif

endmodule

// File: tb/tb_edge_auto_threshold.sv
// Randomized self-checking bench for edge_auto_threshold using small frames
// and a reduced count band (CNT_LO=20, CNT_HI=60) to keep runs short.
module tb_edge_auto_threshold;
  localparam int MAXW = 40;
  localparam int MAXH = 12;
  localparam int CLO  = 20;
  localparam int CHI  = 60;

  logic        pclk = 1'b0;
  logic        rst, sobel_dout, sobel_hs, sobel_vs, sobel_de, update_en;
  logic [10:0] threshold, x_min, x_max, y_min, y_max;
  logic [18:0] edge_count;
  logic        stats_valid, bbox_valid;

  int checks = 0;
  int errors = 0;

  bit px [MAXH][MAXW];
  int fw, fh;

  // reference model: currently expected outputs
  bit          m_armed;
  int          e_th, e_cnt;
  logic        e_bv;
  logic [10:0] e_xmin, e_xmax, e_ymin, e_ymax;

  edge_auto_threshold #(.CNT_LO(19'd20), .CNT_HI(19'd60)) dut (
    .pclk(pclk), .rst(rst), .sobel_dout(sobel_dout), .sobel_hs(sobel_hs),
    .sobel_vs(sobel_vs), .sobel_de(sobel_de), .update_en(update_en),
    .threshold(threshold), .edge_count(edge_count), .stats_valid(stats_valid),
    .bbox_valid(bbox_valid), .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max)
  );

  always #5 pclk = ~pclk;

  function automatic int next_th(input int th, input int cnt, input bit en);
    int t;
    t = th;
    if (en && cnt > CHI) t = th + 8;
    else if (en && cnt < CLO) t = th - 8;
    if (t > 1020) t = 1020;
    if (t < 16) t = 16;
    return t;
  endfunction

  task automatic model_reset();
    m_armed = 1'b0;
    e_th = 100; e_cnt = 0; e_bv = 1'b0;
    e_xmin = 11'd0; e_xmax = 11'd0; e_ymin = 11'd0; e_ymax = 11'd0;
  endtask

  task automatic fill_frame(input int mode, input int w, input int h);
    int n;
    fw = w; fh = h;
    n = $urandom_range(CLO + 1, CHI - 1);
    for (int r = 0; r < MAXH; r++)
      for (int c = 0; c < MAXW; c++) begin
        case (mode)
          1:       px[r][c] = (r < h && c < w);
          2:       px[r][c] = (r < h && c < w) && ($urandom_range(0, 1) == 1);
          3:       px[r][c] = (r < h && c < w) && ((r * w + c) < n);
          default: px[r][c] = 1'b0;
        endcase
      end
  endtask

  task automatic send_pixels(input int lines);
    for (int r = 0; r < lines; r++) begin
      for (int c = 0; c < fw; c++) begin
        @(negedge pclk);
        sobel_de = 1'b1; sobel_hs = 1'b1; sobel_dout = ~px[r][c];
      end
      for (int b = 0; b < 4; b++) begin
        @(negedge pclk);
        sobel_de = 1'b0; sobel_hs = 1'b0; sobel_dout = 1'($urandom_range(0, 1));
      end
    end
  endtask

  // vs rise closing the frame; checks the k, k+1, k+2, k+3 responses
  task automatic end_frame(input string name);
    int cnt, xmn, xmx, ymn, ymx, old_th, new_th;
    cnt = 0; xmn = 2047; xmx = 0; ymn = 2047; ymx = 0;
    for (int r = 0; r < fh; r++)
      for (int c = 0; c < fw; c++)
        if (px[r][c]) begin
          cnt++;
          if (c < xmn) xmn = c;
          if (c > xmx) xmx = c;
          if (r < ymn) ymn = r;
          if (r > ymx) ymx = r;
        end
    old_th = e_th;
    new_th = m_armed ? next_th(e_th, cnt, update_en) : e_th;
    @(negedge pclk);
    sobel_vs = 1'b1; sobel_de = 1'b0;
    @(negedge pclk);
    checks++;
    if (stats_valid !== 1'b0) begin
      errors++; $display("FAIL %s stats_valid@k got %b want 0", name, stats_valid);
    end
    if (m_armed) begin
      e_cnt = cnt;
`ifdef EDGE_AUTO_THRESHOLD_BBOX_EN
      e_bv = (cnt > 0);
      e_xmin = (cnt > 0) ? 11'(xmn) : 11'd0;
      e_xmax = (cnt > 0) ? 11'(xmx) : 11'd0;
      e_ymin = (cnt > 0) ? 11'(ymn) : 11'd0;
      e_ymax = (cnt > 0) ? 11'(ymx) : 11'd0;
`endif
    end
    @(negedge pclk);
    checks++;
    if (edge_count !== 19'(e_cnt)) begin
      errors++; $display("FAIL %s edge_count got %0d want %0d", name, edge_count, e_cnt);
    end
    checks++;
    if ({bbox_valid, x_min, x_max, y_min, y_max} !== {e_bv, e_xmin, e_xmax, e_ymin, e_ymax}) begin
      errors++;
      $display("FAIL %s bbox got v=%b x=%0d..%0d y=%0d..%0d want v=%b x=%0d..%0d y=%0d..%0d",
               name, bbox_valid, x_min, x_max, y_min, y_max, e_bv, e_xmin, e_xmax, e_ymin, e_ymax);
    end
    checks++;
    if ({stats_valid, threshold} !== {1'b0, 11'(old_th)}) begin
      errors++; $display("FAIL %s k+1 sv/th got %b/%0d want 0/%0d", name, stats_valid, threshold, old_th);
    end
    e_th = new_th;
    @(negedge pclk);
    checks++;
    if ({stats_valid, threshold} !== {m_armed, 11'(e_th)}) begin
      errors++; $display("FAIL %s k+2 sv/th got %b/%0d want %b/%0d", name, stats_valid, threshold, m_armed, e_th);
    end
    @(negedge pclk);
    checks++;
    if (stats_valid !== 1'b0) begin
      errors++; $display("FAIL %s stats_valid@k+3 got %b want 0", name, stats_valid);
    end
    sobel_vs = 1'b0;
    m_armed = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
  endtask

  task automatic test_reset();
    rst = 1'b1; sobel_dout = 1'b1; sobel_hs = 1'b0; sobel_vs = 1'b0; sobel_de = 1'b0; update_en = 1'b1;
    model_reset();
    repeat (3) @(negedge pclk);
    checks++;
    if ({threshold, edge_count, stats_valid, bbox_valid, x_min, x_max, y_min, y_max} !==
        {11'd100, 19'd0, 1'b0, 1'b0, 44'd0}) begin
      errors++; $display("FAIL reset_values got th=%0d cnt=%0d sv=%b", threshold, edge_count, stats_valid);
    end
    rst = 1'b0;
    fill_frame(1, 16, 8);
    send_pixels(3);
    end_frame("first_partial");
    fill_frame(1, 16, 8);
    send_pixels(8);
    end_frame("first_full");
    fill_frame(2, 16, 8);
    send_pixels(4);
    @(negedge pclk);
    sobel_de = 1'b1; sobel_dout = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({threshold, edge_count, stats_valid, bbox_valid, x_min, x_max, y_min, y_max} !==
        {11'd100, 19'd0, 1'b0, 1'b0, 44'd0}) begin
      errors++; $display("FAIL midframe_reset got th=%0d cnt=%0d sv=%b", threshold, edge_count, stats_valid);
    end
    model_reset();
    @(negedge pclk);
    sobel_de = 1'b0; rst = 1'b0;
    fill_frame(1, 16, 8);
    send_pixels(5);
    end_frame("after_reset_partial");
  endtask

  task automatic test_above_band();
    update_en = 1'b1;
    fill_frame(1, 16, 8);
    send_pixels(8);
    end_frame("above_band");
    checks++;
    if (threshold !== 11'd108) begin
      errors++; $display("FAIL above_band_th got %0d want 108", threshold);
    end
  endtask

  task automatic test_below_band_saturating();
    update_en = 1'b1;
    for (int i = 0; i < 40 && e_th > 20; i++) begin
      fill_frame(0, 16, 8); send_pixels(8); end_frame("below_walk");
    end
    for (int i = 0; i < 2; i++) begin
      fill_frame(0, 16, 8); send_pixels(8); end_frame("below_sat");
      checks++;
      if (threshold !== 11'd16) begin
        errors++; $display("FAIL below_sat_th got %0d want 16", threshold);
      end
    end
  endtask

  task automatic test_in_band_hold();
    update_en = 1'b1;
    fill_frame(3, 16, 8); send_pixels(8); end_frame("in_band");
    update_en = 1'b0;
    fill_frame(1, 16, 8); send_pixels(8); end_frame("hold_disabled");
    checks++;
    if ({threshold, edge_count} !== {11'd16, 19'd128}) begin
      errors++; $display("FAIL hold_th_cnt got %0d/%0d want 16/128", threshold, edge_count);
    end
    update_en = 1'b1;
  endtask

  task automatic test_bbox();
    fill_frame(0, 40, 12);
    px[5][10] = 1'b1; px[7][30] = 1'b1; px[11][39] = 1'b1;
    send_pixels(12);
    end_frame("bbox_points");
    for (int i = 0; i < 4; i++) begin
      fill_frame(2, $urandom_range(8, 40), $urandom_range(2, 12));
      send_pixels(fh); end_frame("bbox_random");
    end
  endtask

  task automatic test_upper_saturation();
    update_en = 1'b1;
    for (int i = 0; i < 200 && e_th < 1016; i++) begin
      fill_frame(1, 16, 8); send_pixels(8); end_frame("upper_walk");
    end
    for (int i = 0; i < 2; i++) begin
      fill_frame(1, 16, 8); send_pixels(8); end_frame("upper_sat");
      checks++;
      if (threshold !== 11'd1020) begin
        errors++; $display("FAIL upper_sat_th got %0d want 1020", threshold);
      end
    end
  endtask

  task automatic test_random_frames();
    for (int i = 0; i < 15; i++) begin
      update_en = 1'($urandom_range(0, 1));
      fill_frame($urandom_range(0, 3), $urandom_range(8, 40), $urandom_range(2, 12));
      send_pixels(fh);
      end_frame("random");
    end
  endtask

  initial begin
    test_reset();
    test_above_band();
    test_below_band_saturating();
    test_in_band_hold();
    test_bbox();
    test_upper_saturation();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
